mem_bus_unit: RTL
=================

Name: mem_bus_unit

Overview:
- Parametrised memory-bus unit: owns MAR and MDR and runs multi-cycle read/write transactions to an asynchronous active-low SRAM.
- Adds configurable wait states, a busy/response handshake to control, and LC-3b byte (LDB/STB) lane steering.
- Sits between the datapath bus and external SRAM.
- Replaces the bare MAR/MDR registers; control waits on mem_resp instead of fixed-count states.

Parameters:
- DATA_W, 16: bus/MDR width; must be even.
- ADDR_W, 20: SRAM word-address width; ADDR_W >= DATA_W-1.
- WAIT_STATES, 2: extra SRAM access cycles beyond one; range 0..15.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- ld_mar  in  1  load MAR from bus_in (IDLE only).
- ld_mdr  in  1  load MDR from bus_in (IDLE only).
- bus_in  in  DATA_W  datapath bus value.
- mem_read  in  1  read request, sampled in IDLE.
- mem_write  in  1  write request, sampled in IDLE.
- byte_mode  in  1  byte access; sampled with request.
- mdr_out  out  DATA_W  MDR contents.
- busy  out  1  high whenever state != IDLE.
- mem_resp  out  1  one-cycle completion pulse.
- ADDR  out  ADDR_W  SRAM word address.
- mem_rdata  in  DATA_W  SRAM read data.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset (sync, active-high):
  - MAR=0, MDR=0, state IDLE, counter 0.
  - busy=0, mem_resp=0, all strobes high, mem_wdata=0.
  - Reset mid-transaction aborts it: strobes high and no mem_resp in the cycle after the reset edge.
- MAR: DATA_W bits. ADDR = zero-extend(MAR[DATA_W-1:1]) to ADDR_W; MAR[0] selects the byte.
- ld_mar, ld_mdr: take effect at the next edge in IDLE only; ignored while busy. Both may load in the same cycle.
- Request acceptance:
  - In IDLE, mem_read or mem_write is sampled at the edge; byte_mode is latched at that edge.
  - If both are asserted, read wins and the write is dropped.
  - Requests asserted while busy are ignored, not queued.
  - ld_mdr together with mem_write in IDLE: the write uses the newly loaded MDR value.
- States: IDLE, RD, WR_SETUP, WR, RESP. Counter width clog2(WAIT_STATES+1), minimum 1.
- Read (request sampled at edge 0):
  - RD occupies cycles 1..WAIT_STATES+1 with ce_n=0, oe_n=0, we_n=1.
  - The counter loads WAIT_STATES on entry and decrements each cycle.
  - At the edge ending the RD cycle with counter==0: MDR captures the steered data and the state moves to RESP.
  - Word mode: MDR = mem_rdata.
  - Byte mode: MDR = sign-extend of the selected byte (MAR[0]=0 gives rdata[7:0], 1 gives rdata[15:8]).
- Write (request sampled at edge 0):
  - WR_SETUP in cycle 1: ce_n=0, we_n=1, address and data stable.
  - WR in cycles 2..WAIT_STATES+2: ce_n=0, we_n=0.
  - Then RESP.
  - Word mode: mem_wdata = MDR.
  - Byte mode: mem_wdata = {MDR[7:0], MDR[7:0]}.
- Byte lanes: ub_n/lb_n are both 0 in word mode. In byte mode only the selected lane is 0 (MAR[0]=1 is the upper lane). Lanes are driven in every RD/WR/WR_SETUP cycle.
- RESP: lasts one cycle with mem_resp=1, busy=1, strobes high; MDR is valid. Next state is IDLE.
- Latency: read mem_resp in cycle WAIT_STATES+2; write mem_resp in cycle WAIT_STATES+3.
- Back-to-back: a request held high through RESP is accepted at the first IDLE edge, so there is one idle cycle minimum between transactions.
- mem_wdata is registered from MDR at acceptance and held constant through the transaction.

Decomposition:
- lc3b_types gains:
  - mem_state_t enum (IDLE, RD, WR_SETUP, WR, RESP).
  - Constants MEM_BYTE_HI=1 and MEM_STROBE_OFF=1'b1.
- One combinational sub-module, mem_byte_lane: inputs DATA_W, byte_mode, sel. It does read sign-extension, write replication, and ub_n/lb_n generation.
- The FSM, counter and registers stay in mem_bus_unit.

Test Plan:
- Reset then idle: all strobes 1, ADDR=0, busy=0. Assert Reset during RD cycle 2: strobes 1 the next cycle, no mem_resp, MDR=0.
- Word read, WAIT_STATES=2, bus_in=16'h3004 via ld_mar, mem_rdata=16'hBEEF: ADDR=20'h01802, oe_n low cycles 1-3, mem_resp in cycle 4, mdr_out=16'hBEEF.
- Byte read, MAR=16'h3005, mem_rdata=16'h80AA: ub_n=0, lb_n=1, mdr_out=16'hFF80. With MAR=16'h3004: mdr_out=16'hFFAA.
- Byte write, MDR=16'h1234, MAR=16'h0001: we_n=1 in cycle 1, we_n=0 in cycles 2-4, mem_wdata=16'h3434, ub_n=0, lb_n=1, mem_resp in cycle 5.
- Simultaneous mem_read and mem_write: only the read executes. ld_mar with bus_in=16'hFFFF during RD: MAR unchanged. Request held high: second transaction starts after one IDLE cycle.
- WAIT_STATES=0 build: read mem_resp in cycle 2, write mem_resp in cycle 3.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types and constants for the LC-3b memory-bus unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   mem_state_t    - memory-bus FSM states
//   MEM_BYTE_HI    - value of MAR[0] that selects the upper byte lane
//   MEM_STROBE_OFF - inactive level of the active-low SRAM strobes
//   mem_cnt_w()    - wait-state counter width, never less than one bit
package lc3b_types;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR       = 3'd3,
        RESP     = 3'd4
    } mem_state_t;

    localparam int   MEM_BYTE_HI    = 1;
    localparam logic MEM_STROBE_OFF = 1'b1;

    // A zero-wait build still needs a one-bit counter so the register exists.
    function automatic int mem_cnt_w(input int wait_states);
        int w;
        w = $clog2(wait_states + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for LDB/STB: read sign-extension, write replication, lane enables.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are sampled.
//
// Ports:
//   i_byte_mode - 1 = byte access, 0 = full-word access
//   i_sel       - byte select (MAR[0]); MEM_BYTE_HI picks the upper half
//   i_rdata     - raw SRAM read word
//   i_mdr       - MDR value to be written
//   o_rdata     - read value to load into MDR (word or sign-extended byte)
//   o_wdata     - write value for the SRAM data bus (byte copied to both halves)
//   o_ub_n      - upper-lane strobe, active-low
//   o_lb_n      - lower-lane strobe, active-low
module mem_byte_lane
    import lc3b_types::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              i_byte_mode,
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [DATA_W-1:0] i_mdr,
    output logic [DATA_W-1:0] o_rdata,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_ub_n,
    output logic              o_lb_n
);

    localparam int HALF = DATA_W / 2;

    logic              w_sel_hi;
    logic [HALF-1:0]   w_byte;

    assign w_sel_hi = (i_sel == 1'(MEM_BYTE_HI));
    assign w_byte   = w_sel_hi ? i_rdata[DATA_W-1:HALF] : i_rdata[HALF-1:0];

    assign o_rdata  = i_byte_mode ? {{HALF{w_byte[HALF-1]}}, w_byte} : i_rdata;

    // The SRAM picks the byte by lane strobe, so the store byte goes on both halves.
    assign o_wdata  = i_byte_mode ? {i_mdr[HALF-1:0], i_mdr[HALF-1:0]} : i_mdr;

    // Word access enables both lanes; byte access enables only the selected one.
    assign o_ub_n   = i_byte_mode && !w_sel_hi;
    assign o_lb_n   = i_byte_mode &&  w_sel_hi;

endmodule

// File: rtl/mem_bus_unit.sv
// Memory-bus unit: owns MAR/MDR and runs wait-stated read/write cycles to an async SRAM.
// Latency: read mem_resp in cycle WAIT_STATES+2, write mem_resp in cycle WAIT_STATES+3.
// Backpressure: busy is high outside IDLE; requests seen while busy are dropped, not queued.
//
// Ports:
//   Clk, Reset          - clock and synchronous active-high reset
//   ld_mar, ld_mdr      - load MAR/MDR from bus_in (honoured in IDLE only)
//   bus_in              - datapath bus value
//   mem_read, mem_write - transaction requests, sampled in IDLE (read wins)
//   byte_mode           - byte access, latched with the request
//   mdr_out             - MDR contents
//   busy, mem_resp      - handshake to control: busy level, one-cycle completion pulse
//   ADDR                - SRAM word address (MAR without its byte-select bit)
//   mem_rdata           - SRAM read data
//   mem_wdata           - SRAM write data, registered at acceptance
//   mem_*_n             - SRAM strobes, active-low, all registered
module mem_bus_unit
    import lc3b_types::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 20,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              byte_mode,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              mem_resp,
    output logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              mem_ub_n,
    output logic              mem_lb_n
);

    localparam int               CNT_W    = mem_cnt_w(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t        r_state;
    logic [DATA_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_byte_mode;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_ub_n;
    logic              r_lb_n;

    logic              w_idle;
    logic              w_req;
    logic [DATA_W-1:0] w_mar_nxt;
    logic [DATA_W-1:0] w_mdr_nxt;
    logic              w_lane_bm;
    logic [DATA_W-1:0] w_rd_steer;
    logic [DATA_W-1:0] w_wr_steer;
    logic              w_ub_n;
    logic              w_lb_n;
    logic [ADDR_W-1:0] w_addr;

    assign w_idle    = (r_state == IDLE);
    assign w_req     = mem_read || mem_write;

    // In IDLE the lane logic must see the values that will be in MAR/MDR after
    // this edge, so a load in the same cycle as the request is honoured.
    assign w_mar_nxt = (w_idle && ld_mar) ? bus_in : r_mar;
    assign w_mdr_nxt = (w_idle && ld_mdr) ? bus_in : r_mdr;
    assign w_lane_bm = w_idle ? byte_mode : r_byte_mode;

    mem_byte_lane #(
        .DATA_W (DATA_W)
    ) u_byte_lane (
        .i_byte_mode (w_lane_bm),
        .i_sel       (w_mar_nxt[0]),
        .i_rdata     (mem_rdata),
        .i_mdr       (w_mdr_nxt),
        .o_rdata     (w_rd_steer),
        .o_wdata     (w_wr_steer),
        .o_ub_n      (w_ub_n),
        .o_lb_n      (w_lb_n)
    );

    // MAR[0] is the byte select, so the word address is MAR shifted right by one.
    always_comb begin
        w_addr                = '0;
        w_addr[DATA_W-2:0]    = r_mar[DATA_W-1:1];
    end

    // Strobes are registered alongside the state so the SRAM never sees decode glitches.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_byte_mode <= 1'b0;
            r_ce_n      <= MEM_STROBE_OFF;
            r_oe_n      <= MEM_STROBE_OFF;
            r_we_n      <= MEM_STROBE_OFF;
            r_ub_n      <= MEM_STROBE_OFF;
            r_lb_n      <= MEM_STROBE_OFF;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mar <= w_mar_nxt;
                    r_mdr <= w_mdr_nxt;
                    if (w_req) begin
                        r_byte_mode <= byte_mode;
                        r_wdata     <= w_wr_steer;
                        r_cnt       <= CNT_LOAD;
                        r_ce_n      <= 1'b0;
                        r_ub_n      <= w_ub_n;
                        r_lb_n      <= w_lb_n;
                        if (mem_read) begin
                            r_state <= RD;
                            r_oe_n  <= 1'b0;
                        end else begin
                            r_state <= WR_SETUP;
                        end
                    end
                end

                RD: begin
                    if (r_cnt == '0) begin
                        r_mdr   <= w_rd_steer;
                        r_state <= RESP;
                        r_ce_n  <= MEM_STROBE_OFF;
                        r_oe_n  <= MEM_STROBE_OFF;
                        r_ub_n  <= MEM_STROBE_OFF;
                        r_lb_n  <= MEM_STROBE_OFF;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                // One cycle of address/data setup before we_n falls; the
                // counter still holds its load value for the WR phase.
                WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_state <= WR;
                end

                WR: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                        r_ce_n  <= MEM_STROBE_OFF;
                        r_we_n  <= MEM_STROBE_OFF;
                        r_ub_n  <= MEM_STROBE_OFF;
                        r_lb_n  <= MEM_STROBE_OFF;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                RESP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_ce_n  <= MEM_STROBE_OFF;
                    r_oe_n  <= MEM_STROBE_OFF;
                    r_we_n  <= MEM_STROBE_OFF;
                    r_ub_n  <= MEM_STROBE_OFF;
                    r_lb_n  <= MEM_STROBE_OFF;
                end
            endcase
        end
    end

    assign busy      = !w_idle;
    assign mem_resp  = (r_state == RESP);
    assign mdr_out   = r_mdr;
    assign ADDR      = w_addr;
    assign mem_wdata = r_wdata;
    assign mem_ce_n  = r_ce_n;
    assign mem_oe_n  = r_oe_n;
    assign mem_we_n  = r_we_n;
    assign mem_ub_n  = r_ub_n;
    assign mem_lb_n  = r_lb_n;

endmodule
